// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch predictor control stage in front of bp_cache.
// Optional statistics counters are compiled in with `define BP_STATS_EN.
module branch_predictor #(
  parameter int AWIDTH = 32,
  parameter int CWIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] pc_guess,
  input  logic              is_br_guess,
  output logic              br_taken_guess,
  input  logic [AWIDTH-1:0] pc_check,
  input  logic              is_br_check,
  input  logic              br_taken_check,
  output logic [AWIDTH-1:0] ra0,
  input  logic [CWIDTH-1:0] dout0,
  input  logic              hit0,
  output logic [AWIDTH-1:0] ra1,
  input  logic [CWIDTH-1:0] dout1,
  input  logic              hit1,
  output logic [AWIDTH-1:0] wa,
  output logic [CWIDTH-1:0] din,
  output logic              we
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_br_cnt,
  output logic [31:0]       stat_mispred_cnt
`endif
);

  localparam logic [CWIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CWIDTH-1:0] CNT_MIN   = '0;
  localparam logic [CWIDTH-1:0] WEAK_TKN  = {1'b1, {(CWIDTH-1){1'b0}}};
  localparam logic [CWIDTH-1:0] WEAK_NTKN = {1'b0, {(CWIDTH-1){1'b1}}};

  logic              pend_v;
  logic [AWIDTH-1:0] pend_pc;
  logic [CWIDTH-1:0] pend_cnt;
  logic              fwd_guess;
  logic              fwd_check;
  logic              base_hit;
  logic [CWIDTH-1:0] base_cnt;
  logic [CWIDTH-1:0] new_cnt;
  logic              unused_bits;

  assign ra0 = pc_guess;
  assign ra1 = pc_check;
  assign we  = pend_v;
  assign wa  = pend_pc;
  assign din = pend_cnt;

  // The pending write has not landed in bp_cache yet, so it overrides the guess port.
  assign fwd_guess      = pend_v && (pend_pc == pc_guess);
  assign br_taken_guess = is_br_guess & (fwd_guess ? pend_cnt[CWIDTH-1]
                                                   : (hit0 & dout0[CWIDTH-1]));
  assign unused_bits    = ^dout0[CWIDTH-2:0];

  always_comb begin
    fwd_check = pend_v && (pend_pc == pc_check);
    base_cnt  = fwd_check ? pend_cnt : dout1;
    base_hit  = fwd_check | hit1;
    new_cnt   = base_cnt;
    if (base_hit) begin
      if (br_taken_check) begin
        if (base_cnt != CNT_MAX) new_cnt = CWIDTH'(base_cnt + 1'b1);
      end else begin
        if (base_cnt != CNT_MIN) new_cnt = CWIDTH'(base_cnt - 1'b1);
      end
    end else begin
      new_cnt = br_taken_check ? WEAK_TKN : WEAK_NTKN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v   <= 1'b0;
      pend_pc  <= '0;
      pend_cnt <= '0;
    end else begin
      pend_v <= is_br_check;
      if (is_br_check) begin
        pend_pc  <= pc_check;
        pend_cnt <= new_cnt;
      end
    end
  end

`ifdef BP_STATS_EN
  // Check-side prediction is what the guess port would have said for this PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_cnt      <= '0;
      stat_mispred_cnt <= '0;
    end else if (is_br_check) begin
      stat_br_cnt <= stat_br_cnt + 32'd1;
      if ((base_hit & base_cnt[CWIDTH-1]) != br_taken_check)
        stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
    end
  end
`endif

endmodule
